// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter.
// Inhibits the bus, issues request-to-send, then shifts start/d0..d7/parity/stop
// on device clock falls and checks the device ACK on fall 11.
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a stalled frame after
// TIMEOUT_CYCLES clk cycles without a device clock fall.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, WAIT_IDLE} state_t;

  state_t             state, state_n;
  logic [2:0]         c_sync;   // [1] synced clock, [2] previous synced clock
  logic [1:0]         d_sync;   // [1] synced data
  logic               c_s, d_s, fall;
  logic [9:0]         frame, frame_n;     // {stop, parity, d7..d0}, shifted out LSB first
  logic [3:0]         bit_cnt, bit_cnt_n; // device falls seen, 0..11
  logic [INH_W-1:0]   inh_cnt, inh_cnt_n;
  logic               ack, ack_n;         // 1 = device pulled data low on fall 11
  logic               c_oe_n, d_oe_n, done_n, err_n;

  assign c_s  = c_sync[1];
  assign d_s  = d_sync[1];
  assign fall = c_sync[2] & ~c_sync[1];
  assign busy = (state != IDLE);

  // Two-flop synchronisers on the raw pins plus clock history for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync <= 3'b111;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[1:0], ps2c_in};
      d_sync <= {d_sync[0], ps2d_in};
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd, wd_n;

  // Watchdog count of cycles since the last device clock fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd <= '0;
    else       wd <= wd_n;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // State, datapath and registered pin/pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      frame   <= '0;
      bit_cnt <= '0;
      inh_cnt <= '0;
      ack     <= 1'b0;
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
    end else begin
      state   <= state_n;
      frame   <= frame_n;
      bit_cnt <= bit_cnt_n;
      inh_cnt <= inh_cnt_n;
      ack     <= ack_n;
      ps2c_oe <= c_oe_n;
      ps2d_oe <= d_oe_n;
      tx_done <= done_n;
      tx_err  <= err_n;
    end
  end

  // Next-state logic; pin enables are computed for the state being entered.
  always_comb begin
    state_n   = state;
    frame_n   = frame;
    bit_cnt_n = bit_cnt;
    inh_cnt_n = inh_cnt;
    ack_n     = ack;
    c_oe_n    = 1'b0;
    d_oe_n    = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wd_n      = wd;
`endif
    unique case (state)
      IDLE: begin
        if (tx_start) begin
          frame_n   = {1'b1, ~^tx_data, tx_data};
          bit_cnt_n = '0;
          inh_cnt_n = '0;
          ack_n     = 1'b0;
          state_n   = INHIBIT;
          c_oe_n    = 1'b1;
        end
      end
      INHIBIT: begin
        c_oe_n = 1'b1;
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          state_n = RTS;
          d_oe_n  = 1'b1;
        end else begin
          inh_cnt_n = inh_cnt + 1'b1;
        end
      end
      RTS: begin
        // Release clock, keep data low: start bit is on the line.
        state_n = SEND;
        d_oe_n  = 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
        wd_n    = '0;
`endif
      end
      SEND: begin
        d_oe_n = ps2d_oe;
        if (fall) begin
          if (bit_cnt < 4'd10) begin
            d_oe_n    = ~frame[0];
            frame_n   = {1'b1, frame[9:1]};
            bit_cnt_n = bit_cnt + 4'd1;
          end else begin
            bit_cnt_n = 4'd11;
            ack_n     = ~d_s;
            d_oe_n    = 1'b0;
            state_n   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (c_s && d_s) begin
          state_n = IDLE;
          done_n  = ack;
          err_n   = ~ack;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // A completing frame wins over a coincident timeout.
    if (state == SEND || state == WAIT_IDLE) begin
      if (fall) begin
        wd_n = '0;
      end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
        if (state_n != IDLE) begin
          state_n = IDLE;
          c_oe_n  = 1'b0;
          d_oe_n  = 1'b0;
          err_n   = 1'b1;
        end
      end else begin
        wd_n = wd + 1'b1;
      end
    end
`endif
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter: serialises one command byte (e.g. keyboard LED set 0xED, reset 0xFF) from the FPGA onto the PS/2 clock/data lines, using the host request-to-send sequence. It is the opposite direction of the existing `keyboard` scan-code receiver and shares the same `PS2_KBCLK`/`PS2_KBDAT` pins through open-drain enables at the top level. The design supports one outstanding byte; the caller waits for `tx_done` or `tx_err` before issuing the next `tx_start`.

## Interface
- `INHIBIT_CYCLES`, 5000: `clk` cycles the clock line is held low before RTS (100 us at 50 MHz).
- `TIMEOUT_CYCLES`, 1000000: maximum `clk` cycles between device clock falling edges (20 ms). Used only with `PS2_TX_TIMEOUT_EN`.
- `clk`  in  1  system clock, `CLOCK_50`.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  byte to send. Sampled on the `tx_start` acceptance cycle.
- `tx_start`  in  1  request. Accepted only when `busy`=0.
- `ps2c_in`  in  1  raw PS/2 clock pin level (asynchronous).
- `ps2d_in`  in  1  raw PS/2 data pin level (asynchronous).
- `ps2c_oe`  out  1  1 = pull clock pin low. 0 = release (Hi-Z).
- `ps2d_oe`  out  1  1 = pull data pin low. 0 = release.
- `busy`  out  1  transfer in progress.
- `tx_done`  out  1  1-cycle pulse: device acknowledged and the bus has returned to idle.
- `tx_err`  out  1  1-cycle pulse: NACK, or timeout.

## Operation
- Reset values: `ps2c_oe`=0, `ps2d_oe`=0, `busy`=0, `tx_done`=0, `tx_err`=0. State is IDLE.
- Both `ps2c_in` and `ps2d_in` pass through 2-flop synchronisers. A falling edge (`fall`) is registered sync=0 while the previous sync value was 1.
- Frame, LSB first:
  - start bit 0
  - d0..d7
  - odd parity, `~^tx_data`
  - stop bit 1
  - device ACK (data=0)
- Driving rule: bit value b gives `ps2d_oe`=~b.
- FSM states and transitions:
  - IDLE: `tx_start` latches `tx_data` into the shift register, computes parity, clears counters and goes to INHIBIT.
  - INHIBIT: `ps2c_oe`=1, `ps2d_oe`=0 for exactly INHIBIT_CYCLES cycles, then RTS.
  - RTS: `ps2c_oe`=1, `ps2d_oe`=1 for one cycle, then SEND.
  - SEND: `ps2c_oe`=0 and `ps2d_oe` stays 1, so the start bit is on the line.
    - On falls 1..8, drive d0..d7.
    - On fall 9, drive parity.
    - On fall 10, drive stop (`ps2d_oe`=0).
    - On fall 11, sample synced data, then go to WAIT_IDLE.
  - WAIT_IDLE: waits until synced clock=1 and synced data=1.
    - If the fall-11 sample was 0: `tx_done` pulse.
    - Otherwise: `tx_err` pulse.
    - Either way, return to IDLE.
- Bit counter is 4 bits, range 0..11, and never wraps.
- `busy`=1 in every state except IDLE.
- `tx_start` while busy: ignored. No queueing and no error.
- `tx_done` and `tx_err` are mutually exclusive.
- Activity on `ps2c_in` while in IDLE/INHIBIT/RTS is ignored. The host owns the bus in those states.
- Reset asserted mid-frame: both `oe` outputs are 0 immediately (asynchronous), FSM goes to IDLE, no pulse is generated, and the latched byte is discarded.

## Timing
- `tx_start` at cycle N:
  - `busy`=1 and `ps2c_oe`=1 at N+1.
  - `ps2d_oe`=1 at N+1+INHIBIT_CYCLES.
  - `ps2c_oe`=0 at N+2+INHIBIT_CYCLES.
- Pin fall to `ps2d_oe` update: 3 `clk` cycles (2 sync + 1 register). This is far inside the device's ~40 us clock-low half period.
- ACK sample is taken from synced data on the fall-11 detection cycle.
- `tx_done`/`tx_err` assert 1 cycle after the idle condition is seen. `busy` drops in the same cycle as the pulse.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A watchdog counter clears on every `fall` and on entry to SEND.
  - If it reaches TIMEOUT_CYCLES in SEND or WAIT_IDLE: release both lines, pulse `tx_err`, go to IDLE.
- Not defined: no watchdog logic. The FSM waits indefinitely for device clocks, and only `reset` recovers it.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and ACKing. Data pin values on falls 1..10 must be 1,0,1,1,0,1,1,1, parity 1, stop 1. Then `tx_done`=1 for one cycle and `tx_err` stays 0.
- `tx_start` with INHIBIT_CYCLES=5000: `ps2c_oe` high for exactly 5000 cycles, then 1 cycle with both `oe`=1, then `ps2c_oe`=0 with `ps2d_oe`=1.
- Send 0x00 (parity 1) with the model returning data=1 at the ACK clock: `tx_err` pulses once, `tx_done` stays 0, `busy` returns to 0.
- With `PS2_TX_TIMEOUT_EN` and TIMEOUT_CYCLES=1000: device stops clocking after fall 4. `tx_err` pulses 1000 cycles after the last fall, and both `oe`=0. Without the macro, `busy` stays 1.
- Assert `reset` after fall 5 of 0xFF: `ps2c_oe`/`ps2d_oe`/`busy` are 0 before the next `clk` edge. A fresh 0xF4 send then completes with `tx_done`.
- Pulse `tx_start` with 0x55 during an ongoing 0xAA transfer: the line carries only 0xAA bits and exactly one `tx_done` is produced.
